// File: rtl/parking_gate_ctrl.sv
// Purpose : parking gate controller; turns entry/exit/pass sensor edges into gate
//           opening, a saturating occupancy count and one-cycle trigger pulses.
// Latency : sensor sampled high at edge n -> pulse/gate_open/busy after edge n+1.
// Backpressure: none. Requests arriving while a gate is open are held in one-deep
//           pending flags; repeats of the same request merge into that flag.
//
// Ports:
//   CLK, RST             clock and synchronous active-high reset
//   entry_sensor         car waiting at the entry gate (level)
//   exit_sensor          car waiting at the exit gate (level)
//   pass_sensor          car has driven through the open gate (level)
//   door_open_to_entry   one-cycle pulse when the entry gate opens
//   door_open_to_exit    one-cycle pulse when the exit gate opens
//   full_garage          one-cycle pulse when an entry is refused
//   gate_open            high while either gate is open
//   occupancy            cars inside, 0..CAPACITY
//   busy                 controller is not idle
module parking_gate_ctrl #(
    parameter int CAPACITY  = 8,
    parameter int CNT_W     = 4,
    parameter int DOOR_TIME = 50000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             entry_sensor,
    input  logic             exit_sensor,
    input  logic             pass_sensor,
    output logic             door_open_to_entry,
    output logic             door_open_to_exit,
    output logic             full_garage,
    output logic             gate_open,
    output logic [CNT_W-1:0] occupancy,
    output logic             busy
);

    localparam int               TMR_W = (DOOR_TIME > 2) ? $clog2(DOOR_TIME) : 1;
    localparam logic [CNT_W-1:0] CAP_C = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
    localparam logic [TMR_W-1:0] TMO_C = TMR_W'(DOOR_TIME - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_EXIT  = 2'd2
    } state_t;

    // Sensor sample stage and previous-value stage. Both reset to 1 so a
    // sensor that is already high when reset releases is not seen as a new
    // arrival; it has to drop and rise again.
    logic ent_smp_q, ext_smp_q, pas_smp_q;
    logic ent_prev_q, ext_prev_q, pas_prev_q;

    state_t           state_q;
    logic [TMR_W-1:0] timer_q;
    logic [CNT_W-1:0] occ_q;
    logic             ent_pend_q, ext_pend_q;
    logic             open_ent_q, open_ext_q, full_q;
    logic             gate_q, busy_q;

    logic ent_ev, ext_ev, pas_ev;
    logic ent_req, ext_req;
    logic ext_go;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ent_smp_q  <= 1'b1;
            ext_smp_q  <= 1'b1;
            pas_smp_q  <= 1'b1;
            ent_prev_q <= 1'b1;
            ext_prev_q <= 1'b1;
            pas_prev_q <= 1'b1;
        end else begin
            ent_smp_q  <= entry_sensor;
            ext_smp_q  <= exit_sensor;
            pas_smp_q  <= pass_sensor;
            ent_prev_q <= ent_smp_q;
            ext_prev_q <= ext_smp_q;
            pas_prev_q <= pas_smp_q;
        end
    end

    assign ent_ev = ent_smp_q & ~ent_prev_q;
    assign ext_ev = ext_smp_q & ~ext_prev_q;
    assign pas_ev = pas_smp_q & ~pas_prev_q;

    // A request is either a remembered one or one arriving this very cycle,
    // so an idle controller reacts without an extra cycle through the flag.
    assign ent_req = ent_pend_q | ent_ev;
    assign ext_req = ext_pend_q | ext_ev;

    // Exit has priority; an exit with nobody inside is simply discarded.
    assign ext_go = ext_req && (occ_q != '0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            occ_q      <= '0;
            ent_pend_q <= 1'b0;
            ext_pend_q <= 1'b0;
            open_ent_q <= 1'b0;
            open_ext_q <= 1'b0;
            full_q     <= 1'b0;
            gate_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            open_ent_q <= 1'b0;
            open_ext_q <= 1'b0;
            full_q     <= 1'b0;
            // Capture new requests; cleared below when served or dropped.
            ent_pend_q <= ent_req;
            ext_pend_q <= ext_req;

            case (state_q)
                S_IDLE: begin
                    if (ext_req) begin
                        ext_pend_q <= 1'b0;
                    end
                    if (ext_go) begin
                        open_ext_q <= 1'b1;
                        gate_q     <= 1'b1;
                        busy_q     <= 1'b1;
                        timer_q    <= '0;
                        state_q    <= S_EXIT;
                    end else if (ent_req) begin
                        ent_pend_q <= 1'b0;
                        if (occ_q < CAP_C) begin
                            open_ent_q <= 1'b1;
                            gate_q     <= 1'b1;
                            busy_q     <= 1'b1;
                            timer_q    <= '0;
                            state_q    <= S_ENTRY;
                        end else begin
                            full_q <= 1'b1;
                        end
                    end
                end

                S_ENTRY: begin
                    // A pass seen on the timeout cycle still counts.
                    if (pas_ev) begin
                        if (occ_q != CAP_C) begin
                            occ_q <= occ_q + ONE_C;
                        end
                        gate_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        timer_q <= '0;
                        state_q <= S_IDLE;
                    end else if (timer_q == TMO_C) begin
                        gate_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        timer_q <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                S_EXIT: begin
                    if (pas_ev) begin
                        if (occ_q != '0) begin
                            occ_q <= occ_q - ONE_C;
                        end
                        gate_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        timer_q <= '0;
                        state_q <= S_IDLE;
                    end else if (timer_q == TMO_C) begin
                        gate_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        timer_q <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                default: begin
                    gate_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    timer_q <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign door_open_to_entry = open_ent_q;
    assign door_open_to_exit  = open_ext_q;
    assign full_garage        = full_q;
    assign gate_open          = gate_q;
    assign busy               = busy_q;
    assign occupancy          = occ_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed bench for parking_gate_ctrl with CAPACITY=8, CNT_W=4, DOOR_TIME=10.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_parking_gate_ctrl;

    logic       CLK;
    logic       RST;
    logic       entry_sensor, exit_sensor, pass_sensor;
    logic       door_open_to_entry, door_open_to_exit, full_garage;
    logic       gate_open, busy;
    logic [3:0] occupancy;

    int n_checks;
    int n_fail;

    parking_gate_ctrl #(
        .CAPACITY (8),
        .CNT_W    (4),
        .DOOR_TIME(10)
    ) dut (
        .CLK               (CLK),
        .RST               (RST),
        .entry_sensor      (entry_sensor),
        .exit_sensor       (exit_sensor),
        .pass_sensor       (pass_sensor),
        .door_open_to_entry(door_open_to_entry),
        .door_open_to_exit (door_open_to_exit),
        .full_garage       (full_garage),
        .gate_open         (gate_open),
        .occupancy         (occupancy),
        .busy              (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // sel: 0 entry, 1 exit, 2 pass. One-cycle high pulse on the sensor.
    task automatic pulse_in(input int sel);
        case (sel)
            0:       entry_sensor = 1'b1;
            1:       exit_sensor  = 1'b1;
            default: pass_sensor  = 1'b1;
        endcase
        step(1);
        case (sel)
            0:       entry_sensor = 1'b0;
            1:       exit_sensor  = 1'b0;
            default: pass_sensor  = 1'b0;
        endcase
    endtask

    task automatic add_car();
        pulse_in(0);
        step(1);
        pulse_in(2);
        step(1);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step(2);
        RST = 1'b0;
        step(2);
    endtask

    task automatic test_reset();
        entry_sensor = 1'b1;
        RST = 1'b1;
        step(3);
        n_checks++;
        if ({door_open_to_entry, door_open_to_exit, full_garage, gate_open, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {door_open_to_entry, door_open_to_exit, full_garage, gate_open, busy});
        end
        n_checks++;
        if (occupancy !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_occ: got %0d expected 0", occupancy);
        end
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            n_checks++;
            if (door_open_to_entry !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL held_entry_no_event: got pulse=%b busy=%b expected 0 0",
                         door_open_to_entry, busy);
            end
        end
        entry_sensor = 1'b0;
        step(2);
        entry_sensor = 1'b1;
        step(1);
        n_checks++;
        if (door_open_to_entry !== 1'b0) begin
            n_fail++;
            $display("FAIL entry_latency_early: got %b expected 0", door_open_to_entry);
        end
        step(1);
        n_checks++;
        if (door_open_to_entry !== 1'b1 || gate_open !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL entry_open: got pulse=%b gate=%b busy=%b expected 1 1 1",
                     door_open_to_entry, gate_open, busy);
        end
        step(1);
        n_checks++;
        if (door_open_to_entry !== 1'b0 || gate_open !== 1'b1) begin
            n_fail++;
            $display("FAIL entry_pulse_width: got pulse=%b gate=%b expected 0 1",
                     door_open_to_entry, gate_open);
        end
        entry_sensor = 1'b0;
        pulse_in(2);
        n_checks++;
        if (occupancy !== 4'd0) begin
            n_fail++;
            $display("FAIL pass_latency_early: got %0d expected 0", occupancy);
        end
        step(1);
        n_checks++;
        if (occupancy !== 4'd1 || gate_open !== 1'b0) begin
            n_fail++;
            $display("FAIL first_car: got occ=%0d gate=%b expected 1 0", occupancy, gate_open);
        end
    endtask

    task automatic test_full();
        int fg_extra;
        for (int i = 0; i < 7; i++) add_car();
        n_checks++;
        if (occupancy !== 4'd8) begin
            n_fail++;
            $display("FAIL fill_occ: got %0d expected 8", occupancy);
        end
        pulse_in(0);
        step(1);
        n_checks++;
        if (full_garage !== 1'b1 || door_open_to_entry !== 1'b0 || gate_open !== 1'b0) begin
            n_fail++;
            $display("FAIL full_refuse: got full=%b open=%b gate=%b expected 1 0 0",
                     full_garage, door_open_to_entry, gate_open);
        end
        fg_extra = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (full_garage === 1'b1 || gate_open === 1'b1) fg_extra++;
        end
        n_checks++;
        if (fg_extra !== 0) begin
            n_fail++;
            $display("FAIL full_single_pulse: got %0d extra cycles expected 0", fg_extra);
        end
        n_checks++;
        if (occupancy !== 4'd8) begin
            n_fail++;
            $display("FAIL full_occ: got %0d expected 8", occupancy);
        end
    endtask

    task automatic test_exit();
        do_reset();
        pulse_in(1);
        step(1);
        n_checks++;
        if (door_open_to_exit !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL exit_empty: got pulse=%b busy=%b expected 0 0", door_open_to_exit, busy);
        end
        for (int i = 0; i < 3; i++) add_car();
        n_checks++;
        if (occupancy !== 4'd3) begin
            n_fail++;
            $display("FAIL exit_dropped_occ: got %0d expected 3", occupancy);
        end
        pulse_in(1);
        step(1);
        n_checks++;
        if (door_open_to_exit !== 1'b1 || gate_open !== 1'b1) begin
            n_fail++;
            $display("FAIL exit_open: got pulse=%b gate=%b expected 1 1", door_open_to_exit, gate_open);
        end
        pulse_in(2);
        step(1);
        n_checks++;
        if (occupancy !== 4'd2 || gate_open !== 1'b0) begin
            n_fail++;
            $display("FAIL exit_pass: got occ=%0d gate=%b expected 2 0", occupancy, gate_open);
        end
    endtask

    task automatic test_timeout();
        int cnt;
        pulse_in(0);
        step(1);
        cnt = 0;
        while (gate_open === 1'b1 && cnt < 30) begin
            cnt++;
            step(1);
        end
        n_checks++;
        if (cnt !== 10) begin
            n_fail++;
            $display("FAIL timeout_len: got %0d cycles expected 10", cnt);
        end
        n_checks++;
        if (occupancy !== 4'd2) begin
            n_fail++;
            $display("FAIL timeout_occ: got %0d expected 2", occupancy);
        end
        pulse_in(0);
        step(1);
        step(8);
        pulse_in(2);
        n_checks++;
        if (gate_open !== 1'b1) begin
            n_fail++;
            $display("FAIL pass_on_timeout_open: got %b expected 1", gate_open);
        end
        step(1);
        n_checks++;
        if (gate_open !== 1'b0 || occupancy !== 4'd3) begin
            n_fail++;
            $display("FAIL pass_on_timeout: got gate=%b occ=%0d expected 0 3", gate_open, occupancy);
        end
    endtask

    task automatic test_back_to_back();
        add_car();
        entry_sensor = 1'b1;
        exit_sensor  = 1'b1;
        step(1);
        entry_sensor = 1'b0;
        exit_sensor  = 1'b0;
        step(1);
        n_checks++;
        if (door_open_to_exit !== 1'b1 || door_open_to_entry !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_exit_first: got exit=%b entry=%b expected 1 0",
                     door_open_to_exit, door_open_to_entry);
        end
        pulse_in(2);
        step(1);
        n_checks++;
        if (occupancy !== 4'd3 || gate_open !== 1'b0 || door_open_to_entry !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_exit_done: got occ=%0d gate=%b entry=%b expected 3 0 0",
                     occupancy, gate_open, door_open_to_entry);
        end
        step(1);
        n_checks++;
        if (door_open_to_entry !== 1'b1 || gate_open !== 1'b1) begin
            n_fail++;
            $display("FAIL pending_entry: got entry=%b gate=%b expected 1 1",
                     door_open_to_entry, gate_open);
        end
        pulse_in(2);
        step(1);
        n_checks++;
        if (occupancy !== 4'd4) begin
            n_fail++;
            $display("FAIL simul_final_occ: got %0d expected 4", occupancy);
        end
    endtask

    task automatic test_rst_mid();
        pulse_in(0);
        step(1);
        step(5);
        RST = 1'b1;
        step(1);
        RST = 1'b0;
        n_checks++;
        if (gate_open !== 1'b0 || occupancy !== 4'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got gate=%b occ=%0d busy=%b expected 0 0 0",
                     gate_open, occupancy, busy);
        end
        step(2);
        pulse_in(0);
        step(1);
        n_checks++;
        if (door_open_to_entry !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_entry: got %b expected 1", door_open_to_entry);
        end
        pulse_in(2);
        step(1);
        n_checks++;
        if (occupancy !== 4'd1) begin
            n_fail++;
            $display("FAIL post_reset_occ: got %0d expected 1", occupancy);
        end
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        RST          = 1'b1;
        entry_sensor = 1'b0;
        exit_sensor  = 1'b0;
        pass_sensor  = 1'b0;
        test_reset();
        test_full();
        test_exit();
        test_timeout();
        test_back_to_back();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/parking_gate_ctrl.md
# parking_gate_ctrl

Gate controller for the parking design, directly upstream of the door/full-garage blink stage. Turns entry, exit and pass-through sensor events into gate-open control and a saturating occupancy count. Issues the single-cycle door_open_to_entry, door_open_to_exit and full_garage trigger pulses that the blink stage consumes.

## Interface
- CAPACITY, 8: parking spaces; legal range 1 to 2^CNT_W-1
- CNT_W, 4: occupancy width
- DOOR_TIME, 50000: gate-open timeout in CLK cycles, ≥2
- CLK  in  1  single clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- entry_sensor  in  1  car at entry gate (level)
- exit_sensor  in  1  car at exit gate (level)
- pass_sensor  in  1  car has passed the open gate (level)
- door_open_to_entry  out  1  one-cycle pulse when entry gate opens
- door_open_to_exit  out  1  one-cycle pulse when exit gate opens
- full_garage  out  1  one-cycle pulse when an entry is refused
- gate_open  out  1  level; high while a gate is open (state ENTRY or EXIT)
- occupancy  out  CNT_W  cars inside, 0..CAPACITY
- busy  out  1  state ≠ IDLE

## Operation
- All inputs are synchronous to CLK. Debouncing is outside this block.
- Edge detect: each sensor has a registered previous value. An event is input=1 and prev=0.
- Event rules:
  - pass events count only in ENTRY/EXIT.
  - entry/exit events set the one-deep flags ent_pend / ext_pend.
  - Extra events while a flag is already set are merged.
- FSM states: IDLE, ENTRY, EXIT.
- IDLE, evaluated using pending flags OR this cycle's events:
  - Exit first: if exit requested and occupancy>0, pulse door_open_to_exit, clear ext_pend, go EXIT.
  - An exit request with occupancy==0 is dropped: ext_pend cleared, no pulse.
  - Otherwise, if entry requested and occupancy<CAPACITY, pulse door_open_to_entry, clear ent_pend, go ENTRY.
  - If entry requested and occupancy==CAPACITY, pulse full_garage, clear ent_pend, stay IDLE.
  - If entry and exit are requested on the same cycle, exit is served and entry stays pending.
- ENTRY:
  - timer counts from 0.
  - pass event: occupancy+1, go IDLE.
  - timer==DOOR_TIME-1 with no pass: go IDLE, occupancy unchanged.
  - pass on the timeout cycle counts (pass wins).
- EXIT: as ENTRY, but pass decrements occupancy.
- Occupancy saturates at both ends:
  - never exceeds CAPACITY, never wraps below 0;
  - arithmetic is in CNT_W bits, guarded by the IDLE checks.
- At most one of the three pulse outputs is high in any cycle.

## Timing
- Reset values: all pulses 0, gate_open 0, busy 0, occupancy 0, state IDLE, timer 0, pend flags 0.
- Sensor prev registers reset to 1, so a sensor held high through reset does not produce an event.
- RST asserted mid-operation: gate closes, occupancy clears, and pending requests are lost on the next edge.
- Latency: sensor first sampled high at edge n → pulse, gate_open and busy high after edge n+1 (registered outputs).
- Pulse width is exactly 1 cycle.
- pass sampled high at edge m → occupancy updated and gate_open low after edge m+1.
- Timeout: gate_open stays high for exactly DOOR_TIME cycles when no pass occurs.
- Back-to-back service: once back in IDLE, a pending request is served on the next edge. Minimum 1 IDLE cycle between gate openings.

## Test plan
- Reset with entry_sensor held high, then release and re-raise → no pulse at release; one door_open_to_entry pulse after the re-raise; occupancy 0→1 after pass.
- Fill 8 cars with CAPACITY=8, then a 9th entry event → exactly one full_garage pulse, gate_open stays 0, occupancy stays 8.
- Exit event with occupancy 0 → no pulse, state stays IDLE. Exit at occupancy 3 plus pass → occupancy 2.
- DOOR_TIME=10: entry event, no pass → gate_open high for 10 cycles, then low; occupancy unchanged. Repeat with pass on the timeout cycle → occupancy +1.
- Entry and exit raised on the same cycle at occupancy 4 → door_open_to_exit first. After the exit pass (occupancy 3), door_open_to_entry follows on the next IDLE edge; final occupancy 4 after the entry pass.
- RST pulsed while in ENTRY with timer at 5 → next cycle: gate_open 0, occupancy 0, busy 0; a new entry event is then served normally.
